// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback arbiter for the shared register-file write port
//
// Purpose: picks one of two writeback requesters (ALU result, memory load) per
// cycle using round-robin with valid/ready handshakes, lets the memory side lock
// the port for a burst, registers the winning beat onto the register-file write
// port, bypasses that write to the read port, and counts contention cycles.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   alu_valid/addr/data, alu_ready ALU writeback request and accept
//   mem_valid/addr/data/lock,
//   mem_ready                      load writeback request, burst lock, accept
//   rf_we/rf_waddr/rf_wdata        registered write port toward the register file
//   rd_addr, rf_rdata, rd_data     read address, raw read data, bypassed read data
//   conflict_cnt                   saturating count of cycles with both valids high
module regfile_wb_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int LOCK_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_lock,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int LT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [LT_W-1:0] LT_LAST = LT_W'(LOCK_MAX - 1);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [LT_W-1:0]   lock_timer_q, lock_timer_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic alu_fire;
  logic mem_fire;

  assign alu_fire = alu_valid && alu_ready;
  assign mem_fire = mem_valid && mem_ready;

  // State register and all other flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_ARB;
      rr_ptr_q       <= 1'b0;
      lock_timer_q   <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      lock_timer_q   <= lock_timer_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_timer_d = lock_timer_q;
    case (state_q)
      ST_ARB: begin
        if (alu_fire) begin
          rr_ptr_d = 1'b1;
        end else if (mem_fire) begin
          rr_ptr_d = 1'b0;
          if (mem_lock) begin
            state_d      = ST_LOCK;
            lock_timer_d = '0;
          end
        end
      end
      ST_LOCK: begin
        if (mem_fire) begin
          lock_timer_d = '0;
          if (!mem_lock) begin
            state_d  = ST_ARB;
            rr_ptr_d = 1'b0;
          end
        end else if (!mem_valid) begin
          // The idle cycle seen with the timer already at its last value
          // releases the lock; earlier idle cycles just count.
          if (lock_timer_q == LT_LAST) begin
            state_d      = ST_ARB;
            rr_ptr_d     = 1'b0;
            lock_timer_d = '0;
          end else begin
            lock_timer_d = lock_timer_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // Output logic: handshake readies. Neither ready looks at the other ready.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    case (state_q)
      ST_ARB: begin
        alu_ready = alu_valid && (!mem_valid || !rr_ptr_q);
        mem_ready = mem_valid && (!alu_valid || rr_ptr_q);
      end
      ST_LOCK: begin
        mem_ready = mem_valid;
      end
      default: begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
      end
    endcase
  end

  // Write port: at most one requester fires per cycle; address/data hold when idle.
  always_comb begin
    rf_we_d    = alu_fire || mem_fire;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (alu_fire) begin
      rf_waddr_d = alu_addr;
      rf_wdata_d = alu_data;
    end else if (mem_fire) begin
      rf_waddr_d = mem_addr;
      rf_wdata_d = mem_data;
    end
  end

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (alu_valid && mem_valid && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign conflict_cnt = conflict_cnt_q;
  assign rd_data      = (rf_we_q && (rf_waddr_q == rd_addr)) ? rf_wdata_q : rf_rdata;

endmodule
